// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one-cycle write-back.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier path.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [4:0]       rd_idx_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             wr_en_o,
  output logic [4:0]       rd_idx_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [2:0]         r_op;
  logic [4:0]         r_rd_idx;
  logic [CntW-1:0]    r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rd_data;

  logic               w_accept, w_last, w_special, w_fast;
  logic               w_a_neg, w_b_neg, w_neg;
  logic               w_div_zero, w_ovf;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod_s;
  logic [WIDTH-1:0]   w_div_sel, w_result;

  // Accept-time operand decode: sign handling and divide special cases.
  always_comb begin
    w_accept   = start_i & (r_state == StIdle) & ~flush_i;
    w_a_neg    = rs1_data_i[WIDTH-1] & ((op_i == 3'b000) | (op_i == 3'b001) | (op_i == 3'b010) |
                                        (op_i == 3'b100) | (op_i == 3'b110));
    w_b_neg    = rs2_data_i[WIDTH-1] & ((op_i == 3'b000) | (op_i == 3'b001) |
                                        (op_i == 3'b100) | (op_i == 3'b110));
    w_a_mag    = w_a_neg ? -rs1_data_i : rs1_data_i;
    w_b_mag    = w_b_neg ? -rs2_data_i : rs2_data_i;
    w_neg      = (op_i[2] & op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = op_i[2] & (rs2_data_i == '0);
    w_ovf      = op_i[2] & ~op_i[0] & (rs1_data_i == MinVal) & (rs2_data_i == '1);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = op_i[1] ? rs1_data_i : '1;
    end else begin
      w_special_res = op_i[1] ? '0 : rs1_data_i;
    end
`ifdef MULDIV_FAST_MUL_EN
    w_fast = ~op_i[2];
`else
    w_fast = 1'b0;
`endif
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag, w_fast_prod;
  logic [WIDTH-1:0]   w_fast_res;
  always_comb begin
    w_fast_mag  = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
    w_fast_prod = w_neg ? -w_fast_mag : w_fast_mag;
    w_fast_res  = (op_i == 3'b000) ? w_fast_prod[WIDTH-1:0] : w_fast_prod[2*WIDTH-1:WIDTH];
  end
`endif

  // One iteration step; r_acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    w_last   = (r_cnt == CntW'(WIDTH - 1));
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (r_op[2]) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end
    w_prod_s  = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_div_sel = r_op[1] ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
    if (r_op[2]) begin
      w_result = r_neg ? -w_div_sel : w_div_sel;
    end else if (r_op == 3'b000) begin
      w_result = w_prod_s[WIDTH-1:0];
    end else begin
      w_result = w_prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = (w_special | w_fast) ? StDone : StCalc;
      end
      StCalc: begin
        if (flush_i)     w_state_nxt = StIdle;
        else if (w_last) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_op      <= '0;
      r_rd_idx  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rd_data <= '0;
    end else if (w_accept) begin
      r_op     <= op_i;
      r_rd_idx <= rd_idx_i;
      r_cnt    <= '0;
      r_neg    <= w_neg;
      if (op_i[2]) begin
        r_b   <= w_b_mag;
        r_acc <= {{WIDTH{1'b0}}, w_a_mag};
      end else begin
        r_b   <= w_a_mag;
        r_acc <= {{WIDTH{1'b0}}, w_b_mag};
      end
      if (w_special) r_rd_data <= w_special_res;
`ifdef MULDIV_FAST_MUL_EN
      if (w_fast) r_rd_data <= w_fast_res;
`endif
    end else if ((r_state == StCalc) && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CntW'(1);
      if (w_last) r_rd_data <= w_result;
    end
  end

  assign ready_o   = (r_state == StIdle);
  assign wr_en_o   = (r_state == StDone) & ~flush_i;
  assign rd_idx_o  = r_rd_idx;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, special cases, flush and reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   rd = '0;
  logic         ready_o, wr_en_o;
  logic [4:0]   rd_idx_o;
  logic [W-1:0] rd_data_o;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .start_i   (start),
    .op_i      (op),
    .rs1_data_i(a),
    .rs2_data_i(b),
    .rd_idx_i  (rd),
    .flush_i   (flush),
    .ready_o   (ready_o),
    .wr_en_o   (wr_en_o),
    .rd_idx_o  (rd_idx_o),
    .rd_data_o (rd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   idx;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  localparam int DivLat = W + 1;
  localparam int SpcLat = 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && wr_en_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got idx %0d data %h expected no write", rd_idx_o, rd_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_idx", 64'(rd_idx_o), 64'(mon_e.idx));
        chk("wb_data", 64'(rd_data_o), 64'(mon_e.data));
        chk("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // lat = cycles from the cycle start is sampled to the wr_en cycle.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] r, input logic [W-1:0] ex, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
      return;
    end
    op = o; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{r, ex, cyc - 1 + lat});
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_rd_idx", 64'(rd_idx_o), 64'd0);
    chk("rst_rd_data", 64'(rd_data_o), 64'd0);
    rstn = 1'b1;

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulLat, 1'b1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MulLat, 1'b1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, MulLat, 1'b1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, MulLat, 1'b1);
    issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, DivLat, 1'b1);
    issue(3'b111, 32'd100, 32'd7, 5'd10, 32'd2, DivLat, 1'b1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, DivLat, 1'b1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, DivLat, 1'b1);
    issue(3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, SpcLat, 1'b1);
    issue(3'b110, 32'd5, 32'd0, 5'd14, 32'd5, SpcLat, 1'b1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, SpcLat, 1'b1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0, SpcLat, 1'b1);

    // start_i while busy must be ignored: only the DIVU writes back.
    issue(3'b101, 32'd1000, 32'd10, 5'd16, 32'd100, DivLat, 1'b1);
    repeat (3) @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd3; rd = 5'd20; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;

    // Flush at CALC cycle 10: no write, ready next cycle.
    issue(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, DivLat, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_ready", 64'(ready_o), 64'd1);
    chk("flush_wr_en", 64'(wr_en_o), 64'd0);
    @(negedge clk);
    flush = 1'b0;

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    op = 3'b101; a = 32'd9; b = 32'd3; rd = 5'd21; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_blocks_accept", 64'(ready_o), 64'd1);
    start = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-CALC.
    issue(3'b101, 32'd50, 32'd5, 5'd17, 32'd10, DivLat, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
    chk("midrst_rd_idx", 64'(rd_idx_o), 64'd0);
    chk("midrst_rd_data", 64'(rd_data_o), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    issue(3'b101, 32'd100, 32'd7, 5'd4, 32'd14, DivLat, 1'b1);
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulLat, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
